// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, stall back-pressure and
// synchronous flush. SKID_EN=1 adds a second (skid) entry so in_ready comes
// straight from a flop and never depends on out_ready of the same cycle.
// SKID_EN=0 keeps a single entry with a combinational in_ready.
module pipe_stage_skid #(
  parameter int DATA_W  = 129,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              emit;
  logic [DATA_W-1:0] m_data;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign out_data = m_data;

  if (SKID_EN) begin : g_skid
    // Encoding chosen so bit0 is the main-entry valid and bit1 the skid-entry
    // valid; outputs then come directly off the state flops.
    typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              load_m;
    logic              load_m_from_s;
    logic              load_s;
    logic [DATA_W-1:0] s_data;

    // Next-state and register-load decode.
    always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      state_d       = state_q;
      load_m        = 1'b0;
      load_m_from_s = 1'b0;
      load_s        = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            load_m  = 1'b1;
          end
        end
        ST_ONE: begin
          if (emit && accept) begin
            load_m = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            state_d = ST_FULL;
            load_s  = 1'b1;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d       = ST_ONE;
            load_m_from_s = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // Flush kills everything held and drops any same-cycle accept; data
      // registers are left alone since they are don't-care while invalid.
      if (flush) begin
        state_d       = ST_EMPTY;
        load_m        = 1'b0;
        load_m_from_s = 1'b0;
        load_s        = 1'b0;
      end
    end

    // State register; reset wins over flush and all transfers.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!reset) state_q <= ST_EMPTY;
      else        state_q <= state_d;
    end

    // Payload registers for the main and skid entries.
    always_ff @(posedge clk) begin
      // NOTE: the payload registers are reset too, because out_data must read
      // zero after reset rather than stale or X contents.
      if (!reset) begin
        m_data <= '0;
        s_data <= '0;
      end else begin
        if (load_m)             m_data <= in_data;
        else if (load_m_from_s) m_data <= s_data;
        if (load_s)             s_data <= in_data;
      end
    end

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};

  end else begin : g_single
    logic m_valid;

    // Single entry: load on accept, drain on emit without a replacement.
    always_ff @(posedge clk) begin
      if (!reset) begin
        m_valid <= 1'b0;
        m_data  <= '0;
      end else if (flush) begin
        m_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data  <= in_data;
      end else if (emit) begin
        m_valid <= 1'b0;
      end
    end

    assign out_valid = m_valid;
    assign in_ready  = ~m_valid | out_ready;
    assign occupancy = {1'b0, m_valid};
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: one instance with the skid buffer,
// one without, driven from shared inputs. Directed vector table, hand-written
// sequence for the single-entry bypass case, then randomized traffic checked
// against a queue-based reference model of each stage.
module tb_pipe_stage_skid;

  localparam int DATA_W = 129;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  logic              s0_in_ready;
  logic              s0_out_valid;
  logic [DATA_W-1:0] s0_out_data;
  logic [1:0]        s0_occupancy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s0_in_ready), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready), .out_data(s0_out_data),
    .occupancy(s0_occupancy)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    string             name;
    logic              rst;
    logic              fl;
    logic              iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic              chk_od;
    logic              e_ir;
    logic [1:0]        e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic fl, logic iv,
                              logic [DATA_W-1:0] d, logic ordy, logic e_ov,
                              logic [DATA_W-1:0] e_od, logic chk_od,
                              logic e_ir, logic [1:0] e_occ);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od; v.e_ir = e_ir;
    v.e_occ = e_occ;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [DATA_W-1:0] d, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // Reference model state: queue of live payloads per instance.
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q0[$];

  initial begin
    logic e_ir1, e_ir0, acc1, acc0, emt1, emt0;

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // rows: name, rst, flush, in_valid, in_data, out_ready ->
    //       out_valid, out_data, check_data, in_ready, occupancy (after edge)
    vecs.push_back(mk("t1_rst_a",    0,0,1,'h5,  0, 0,'h0,  1, 1,2'd0));
    vecs.push_back(mk("t1_rst_b",    0,0,1,'h5,  0, 0,'h0,  1, 1,2'd0));
    vecs.push_back(mk("t2_s100",     1,0,1,'h100,1, 1,'h100,1, 1,2'd1));
    vecs.push_back(mk("t2_s104",     1,0,1,'h104,1, 1,'h104,1, 1,2'd1));
    vecs.push_back(mk("t2_s108",     1,0,1,'h108,1, 1,'h108,1, 1,2'd1));
    vecs.push_back(mk("t2_drain",    1,0,0,'h0,  1, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t3_pushA",    1,0,1,'hA,  0, 1,'hA,  1, 1,2'd1));
    vecs.push_back(mk("t3_pushB",    1,0,1,'hB,  0, 1,'hA,  1, 0,2'd2));
    vecs.push_back(mk("t3_blockC",   1,0,1,'hC,  0, 1,'hA,  1, 0,2'd2));
    vecs.push_back(mk("t3_idle_chg", 1,0,0,'hFF, 0, 1,'hA,  1, 0,2'd2));
    vecs.push_back(mk("t3_emitA",    1,0,0,'h0,  1, 1,'hB,  1, 1,2'd1));
    vecs.push_back(mk("t3_emitB",    1,0,0,'h0,  1, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t4_pushA",    1,0,1,'hA,  0, 1,'hA,  1, 1,2'd1));
    vecs.push_back(mk("t4_pushB",    1,0,1,'hB,  0, 1,'hA,  1, 0,2'd2));
    vecs.push_back(mk("t4_flush",    1,1,1,'hC,  0, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t4_after",    1,0,0,'h0,  1, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t4_pushD",    1,0,1,'hD,  0, 1,'hD,  1, 1,2'd1));
    vecs.push_back(mk("t4_flush1",   1,1,1,'hE,  1, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t4_after1",   1,0,0,'h0,  1, 0,'h0,  0, 1,2'd0));
    vecs.push_back(mk("t5_pushA",    1,0,1,'hA,  0, 1,'hA,  1, 1,2'd1));
    vecs.push_back(mk("t5_pushB",    1,0,1,'hB,  0, 1,'hA,  1, 0,2'd2));
    vecs.push_back(mk("t5_rst",      0,1,1,'h7,  1, 0,'h0,  1, 1,2'd0));
    vecs.push_back(mk("t5_after",    1,0,0,'h0,  1, 0,'h0,  1, 1,2'd0));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].fl, vecs[k].iv, vecs[k].d, vecs[k].ordy);
      @(posedge clk);
      #1;
      check({vecs[k].name, ".out_valid"}, DATA_W'(out_valid), DATA_W'(vecs[k].e_ov));
      check({vecs[k].name, ".in_ready"},  DATA_W'(in_ready),  DATA_W'(vecs[k].e_ir));
      check({vecs[k].name, ".occupancy"}, DATA_W'(occupancy), DATA_W'(vecs[k].e_occ));
      if (vecs[k].chk_od)
        check({vecs[k].name, ".out_data"}, out_data, vecs[k].e_od);
    end

    // Single-entry stage: in_ready follows out_ready in the same cycle and a
    // replacement is taken on the draining edge with no bubble.
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    check("t6_rst.occupancy", DATA_W'(s0_occupancy), DATA_W'(0));
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 'h11, 1'b0);
    #1 check("t6_empty.in_ready", DATA_W'(s0_in_ready), DATA_W'(1));
    @(posedge clk); #1;
    check("t6_load.out_data", s0_out_data, 'h11);
    check("t6_load.occupancy", DATA_W'(s0_occupancy), DATA_W'(1));
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 'h22, 1'b0);
    #1 check("t6_stall.in_ready", DATA_W'(s0_in_ready), DATA_W'(0));
    @(posedge clk); #1;
    check("t6_hold.out_data", s0_out_data, 'h11);
    @(negedge clk); out_ready = 1'b1;
    #1 check("t6_release.in_ready", DATA_W'(s0_in_ready), DATA_W'(1));
    @(posedge clk); #1;
    check("t6_replace.out_valid", DATA_W'(s0_out_valid), DATA_W'(1));
    check("t6_replace.out_data", s0_out_data, 'h22);
    check("t6_replace.occupancy", DATA_W'(s0_occupancy), DATA_W'(1));

    // Randomized traffic against the queue model; start from a clean reset.
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    q1.delete(); q0.delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 2) != 0);
      #1;
      e_ir1 = (q1.size() < 2);
      e_ir0 = (q0.size() == 0) || out_ready;
      check("rnd_skid.in_ready",   DATA_W'(in_ready),     DATA_W'(e_ir1));
      check("rnd_skid.out_valid",  DATA_W'(out_valid),    DATA_W'(q1.size() != 0));
      check("rnd_skid.occupancy",  DATA_W'(occupancy),    DATA_W'(q1.size()));
      if (q1.size() != 0) check("rnd_skid.out_data", out_data, q1[0]);
      check("rnd_single.in_ready", DATA_W'(s0_in_ready),  DATA_W'(e_ir0));
      check("rnd_single.out_valid",DATA_W'(s0_out_valid), DATA_W'(q0.size() != 0));
      check("rnd_single.occupancy",DATA_W'(s0_occupancy), DATA_W'(q0.size()));
      if (q0.size() != 0) check("rnd_single.out_data", s0_out_data, q0[0]);
      acc1 = in_valid && e_ir1;
      acc0 = in_valid && e_ir0;
      emt1 = (q1.size() != 0) && out_ready;
      emt0 = (q0.size() != 0) && out_ready;
      @(posedge clk);
      if (!reset || flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (emt1) void'(q1.pop_front());
        if (acc1) q1.push_back(in_data);
        if (emt0) void'(q0.pop_front());
        if (acc0) q0.push_back(in_data);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
